// File: rtl/verinject_mem_fault_table_if.sv
// Bus bundle between a memory wrapper and its fault table.
//
// Signalling: there is no valid/ready pair on this bus. do_read and do_write
// are single-cycle strobes that the table accepts unconditionally on every
// rising clock edge. verinject__injector_state is a level that is sampled
// every cycle. modified is a combinational response to do_read,
// read_address and unmodified in the same cycle. fault_count, overflow and
// injected are registered status outputs.
interface verinject_mem_fault_table_if #(
  parameter int LEFT       = 0,
  parameter int RIGHT      = 0,
  parameter int ADDR_LEFT  = 0,
  parameter int ADDR_RIGHT = 0
);
  logic [31:0]                  verinject__injector_state;
  logic                         do_read;
  logic [LEFT:RIGHT]            unmodified;
  logic [ADDR_LEFT:ADDR_RIGHT]  read_address;
  logic [LEFT:RIGHT]            modified;
  logic                         do_write;
  logic [ADDR_LEFT:ADDR_RIGHT]  write_address;
  logic [4:0]                   fault_count;
  logic                         overflow;
  logic                         injected;

  // Memory wrapper / stimulus side
  modport master (
    output verinject__injector_state, do_read, unmodified, read_address,
           do_write, write_address,
    input  modified, fault_count, overflow, injected
  );

  // Fault table side
  modport slave (
    input  verinject__injector_state, do_read, unmodified, read_address,
           do_write, write_address,
    output modified, fault_count, overflow, injected
  );
endinterface

// File: rtl/verinject_mem_fault_table.sv
// Fault table for one memory instance. A global injector state selects one
// bit of one word; the table records per-address XOR masks and applies them
// to read data. Writes repair faults unless STICKY is set.
module verinject_mem_fault_table #(
  parameter int LEFT       = 0,
  parameter int RIGHT      = 0,
  parameter int ADDR_LEFT  = 0,
  parameter int ADDR_RIGHT = 0,
  parameter int D_START    = 0,
  parameter int ENTRIES    = 4,
  parameter int STICKY     = 0
) (
  input logic                         clock,
  input logic                         reset_n,
  verinject_mem_fault_table_if.slave  bus
);

  localparam int W     = (LEFT >= RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1);
  localparam int AW    = (ADDR_LEFT >= ADDR_RIGHT) ? (ADDR_LEFT - ADDR_RIGHT + 1)
                                                   : (ADDR_RIGHT - ADDR_LEFT + 1);
  localparam int LOG2W = $clog2(W);
  // Number of fault bits owned by this memory: (2^AW) * W
  localparam logic [32:0] LIMIT  = 33'd1 << (AW + LOG2W);
  localparam logic [31:0] IDLE   = 32'hFFFF_FFFF;
  localparam logic [31:0] D_BASE = 32'(D_START);

  // Table state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [AW-1:0]      addr_q [ENTRIES];
  logic [AW-1:0]      addr_d [ENTRIES];
  logic [W-1:0]       mask_q [ENTRIES];
  logic [W-1:0]       mask_d [ENTRIES];
  logic [31:0]        prev_state;
  logic [4:0]         fault_count_q, count_d;
  logic               overflow_q, injected_q;

  // Normalised views of the bus: bit 0 is always the RIGHT / ADDR_RIGHT end
  logic [W-1:0]  unmod_w, mod_w, rd_mask;
  logic [AW-1:0] rd_addr, wr_addr;

  // Trigger decode
  logic [31:0]   state, off, bit_idx;
  logic          trigger, hit, free_found;
  logic [AW-1:0] trig_addr;
  logic [W-1:0]  trig_onehot;

  assign state   = bus.verinject__injector_state;
  assign unmod_w = bus.unmodified;
  assign rd_addr = bus.read_address;
  assign wr_addr = bus.write_address;

  assign off         = state - D_BASE;
  assign bit_idx     = off & 32'(W - 1);
  assign trig_addr   = AW'(off >> LOG2W);
  assign trig_onehot = W'(1) << bit_idx;
  assign trigger     = (state != prev_state) && (state != IDLE) &&
                       (state >= D_BASE) && ({1'b0, off} < LIMIT);

  // Next table: write-repair first, then toggle a matching entry or allocate
  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    hit        = 1'b0;
    free_found = 1'b0;
    if ((STICKY == 0) && bus.do_write) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && (addr_q[i] == wr_addr)) begin
          valid_d[i] = 1'b0;
          mask_d[i]  = '0;
        end
      end
    end
    if (trigger) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_d[i] && (addr_d[i] == trig_addr)) begin
          hit       = 1'b1;
          mask_d[i] = mask_d[i] ^ trig_onehot;
          if (mask_d[i] == '0) valid_d[i] = 1'b0;
        end
      end
      if (!hit) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!valid_d[i] && !free_found) begin
            free_found = 1'b1;
            valid_d[i] = 1'b1;
            addr_d[i]  = trig_addr;
            mask_d[i]  = trig_onehot;
          end
        end
      end
    end
  end

  // Popcount of the next valid vector, registered alongside the table
  always_comb begin
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) count_d = count_d + 5'(valid_d[i]);
  end

  // Table, previous state and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= '0;
      prev_state    <= IDLE;
      fault_count_q <= '0;
      overflow_q    <= 1'b0;
      injected_q    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        addr_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      prev_state    <= state;
      fault_count_q <= count_d;
      injected_q    <= trigger && (hit || free_found);
      if (trigger && !hit && !free_found) overflow_q <= 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        addr_q[i] <= addr_d[i];
        mask_q[i] <= mask_d[i];
      end
    end
  end

  // Zero-latency read path using the registered table only
  always_comb begin
    rd_mask = '0;
    if (bus.do_read) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && (addr_q[i] == rd_addr)) rd_mask = rd_mask | mask_q[i];
      end
    end
  end

  assign mod_w           = unmod_w ^ rd_mask;
  assign bus.modified    = mod_w;
  assign bus.fault_count = fault_count_q;
  assign bus.overflow    = overflow_q;
  assign bus.injected    = injected_q;

endmodule

// File: tb/tb_verinject_mem_fault_table.sv
// Bench for verinject_mem_fault_table: W=8, 4-bit address, D_START=100,
// two entries, write-repair mode.
module tb_verinject_mem_fault_table;

  logic clock;
  logic reset_n;
  int   runs;
  int   fails;
  int   pulses;
  logic [7:0] exp_q[$];

  verinject_mem_fault_table_if #(.LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0)) bus ();

  verinject_mem_fault_table #(
    .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0),
    .D_START(100), .ENTRIES(2), .STICKY(0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one read; the expected data goes into the scoreboard queue and is
  // popped and compared once the combinational output has settled
  task automatic drive_read(input string name, input logic rd, input logic [3:0] a,
                            input logic [7:0] u, input logic [7:0] e);
    logic [7:0] x;
    bus.do_read      = rd;
    bus.read_address = a;
    bus.unmodified   = u;
    exp_q.push_back(e);
    #1;
    x = exp_q.pop_front();
    runs++;
    if (bus.modified !== x) begin
      fails++;
      $display("FAIL %s: modified got %h want %h", name, bus.modified, x);
    end
    bus.do_read = 1'b0;
  endtask

  task automatic apply_reset();
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    bus.do_read = 1'b0;
    bus.do_write = 1'b0;
    bus.read_address = '0;
    bus.write_address = '0;
    bus.unmodified = '0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    #2;
    reset_n = 1'b0;
    tick();
    runs++;
    if (bus.fault_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.fault_count); end
    runs++;
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL reset_injected: got %b want 0", bus.injected); end
    drive_read("reset_read", 1'b1, 4'd5, 8'h5A, 8'h5A);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_inject();
    apply_reset();
    bus.verinject__injector_state = 32'd143;
    drive_read("trigger_cycle_old_table", 1'b1, 4'd5, 8'h00, 8'h00);
    tick();
    runs++;
    if (bus.injected !== 1'b1) begin fails++; $display("FAIL single_pulse: got %b want 1", bus.injected); end
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL single_count: got %0d want 1", bus.fault_count); end
    drive_read("single_read", 1'b1, 4'd5, 8'h00, 8'h08);
    drive_read("single_no_strobe", 1'b0, 4'd5, 8'h00, 8'h00);
    drive_read("single_other_addr", 1'b1, 4'd4, 8'h00, 8'h00);
    tick();
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL hold_no_retrigger: got %b want 0", bus.injected); end
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL hold_count: got %0d want 1", bus.fault_count); end
  endtask

  // Continues from test_single_inject
  task automatic test_write_repair();
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    bus.do_write = 1'b1;
    bus.write_address = 4'd5;
    tick();
    bus.do_write = 1'b0;
    runs++;
    if (bus.fault_count !== 5'd0) begin fails++; $display("FAIL repair_count: got %0d want 0", bus.fault_count); end
    drive_read("repair_read", 1'b1, 4'd5, 8'hA5, 8'hA5);
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.verinject__injector_state = 32'd143;
    tick();
    bus.verinject__injector_state = 32'd108;
    tick();
    runs++;
    if (bus.fault_count !== 5'd2) begin fails++; $display("FAIL ovf_fill_count: got %0d want 2", bus.fault_count); end
    bus.verinject__injector_state = 32'd123;
    tick();
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL ovf_no_pulse: got %b want 0", bus.injected); end
    runs++;
    if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    runs++;
    if (bus.fault_count !== 5'd2) begin fails++; $display("FAIL ovf_count: got %0d want 2", bus.fault_count); end
    drive_read("ovf_dropped_addr", 1'b1, 4'd2, 8'h3C, 8'h3C);
    drive_read("ovf_addr1", 1'b1, 4'd1, 8'h00, 8'h01);
    drive_read("ovf_addr5", 1'b1, 4'd5, 8'hFF, 8'hF7);
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    bus.do_write = 1'b1;
    bus.write_address = 4'd5;
    tick();
    bus.do_write = 1'b0;
    tick();
    runs++;
    if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL ovf_after_write: got %0d want 1", bus.fault_count); end
  endtask

  task automatic test_cancel();
    apply_reset();
    pulses = 0;
    bus.verinject__injector_state = 32'd143;
    tick();
    if (bus.injected === 1'b1) pulses++;
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    tick();
    if (bus.injected === 1'b1) pulses++;
    bus.verinject__injector_state = 32'd143;
    tick();
    if (bus.injected === 1'b1) pulses++;
    runs++;
    if (pulses !== 2) begin fails++; $display("FAIL cancel_pulses: got %0d want 2", pulses); end
    runs++;
    if (bus.fault_count !== 5'd0) begin fails++; $display("FAIL cancel_count: got %0d want 0", bus.fault_count); end
    drive_read("cancel_read", 1'b1, 4'd5, 8'h00, 8'h00);
  endtask

  task automatic test_range();
    apply_reset();
    bus.verinject__injector_state = 32'd99;
    tick();
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL below_start_pulse: got %b want 0", bus.injected); end
    bus.verinject__injector_state = 32'd228;
    tick();
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL above_end_pulse: got %b want 0", bus.injected); end
    runs++;
    if (bus.fault_count !== 5'd0) begin fails++; $display("FAIL range_count: got %0d want 0", bus.fault_count); end
    bus.verinject__injector_state = 32'd227;
    tick();
    bus.verinject__injector_state = 32'd100;
    tick();
    runs++;
    if (bus.fault_count !== 5'd2) begin fails++; $display("FAIL edges_count: got %0d want 2", bus.fault_count); end
    drive_read("last_bit", 1'b1, 4'd15, 8'h00, 8'h80);
    drive_read("first_bit", 1'b1, 4'd0, 8'h00, 8'h01);
  endtask

  // Write and trigger on one address in the same cycle, then a second bit
  task automatic test_back_to_back();
    apply_reset();
    bus.verinject__injector_state = 32'd143;
    tick();
    bus.verinject__injector_state = 32'd144;
    bus.do_write = 1'b1;
    bus.write_address = 4'd5;
    tick();
    bus.do_write = 1'b0;
    runs++;
    if (bus.injected !== 1'b1) begin fails++; $display("FAIL wr_trig_pulse: got %b want 1", bus.injected); end
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL wr_trig_count: got %0d want 1", bus.fault_count); end
    drive_read("wr_trig_read", 1'b1, 4'd5, 8'h00, 8'h10);
    bus.verinject__injector_state = 32'd145;
    tick();
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL merge_count: got %0d want 1", bus.fault_count); end
    drive_read("merge_read", 1'b1, 4'd5, 8'hFF, 8'hCF);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.verinject__injector_state = 32'd143;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    runs++;
    if (bus.fault_count !== 5'd0) begin fails++; $display("FAIL mid_reset_count: got %0d want 0", bus.fault_count); end
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL mid_reset_pulse: got %b want 0", bus.injected); end
    drive_read("mid_reset_read", 1'b1, 4'd5, 8'h00, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    runs++;
    if (bus.injected !== 1'b1) begin fails++; $display("FAIL retrigger_pulse: got %b want 1", bus.injected); end
    runs++;
    if (bus.fault_count !== 5'd1) begin fails++; $display("FAIL retrigger_count: got %0d want 1", bus.fault_count); end
    tick();
    runs++;
    if (bus.injected !== 1'b0) begin fails++; $display("FAIL retrigger_once: got %b want 0", bus.injected); end
    drive_read("retrigger_read", 1'b1, 4'd5, 8'h00, 8'h08);
  endtask

  initial begin
    runs  = 0;
    fails = 0;
    pulses = 0;
    bus.verinject__injector_state = 32'hFFFF_FFFF;
    bus.do_read = 1'b0;
    bus.do_write = 1'b0;
    bus.read_address = '0;
    bus.write_address = '0;
    bus.unmodified = '0;
    test_reset();
    test_single_inject();
    test_write_repair();
    test_overflow();
    test_cancel();
    test_range();
    test_back_to_back();
    test_reset_mid();
    runs++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule

// File: doc/verinject_mem_fault_table.md
VERINJECT_MEM_FAULT_TABLE -- requirements
Module: verinject_mem_fault_table

Interface
REQ-001 Parameter LEFT, default 0, MSB index of the data word; W = |LEFT-RIGHT|+1 SHALL be a power of two.
REQ-002 Parameter RIGHT, default 0, LSB index of the data word.
REQ-003 Parameter ADDR_LEFT, default 0, MSB index of the address; AW = |ADDR_LEFT-ADDR_RIGHT|+1, AW+log2(W) <= 31.
REQ-004 Parameter ADDR_RIGHT, default 0, LSB index of the address.
REQ-005 Parameter D_START, default 0, first global fault-bit index owned by this memory.
REQ-006 Parameter ENTRIES, default 4 (range 1..16), fault table depth.
REQ-007 Parameter STICKY, default 0; 0 = writes repair faults, 1 = faults survive writes.
REQ-008 clock  in  1  single clock; all state updates on the rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 verinject__injector_state  in  32  global fault-bit index; 32'hFFFFFFFF = idle.
REQ-011 do_read  in  1  read strobe.
REQ-012 unmodified  in  [LEFT:RIGHT]  raw memory read data.
REQ-013 read_address  in  [ADDR_LEFT:ADDR_RIGHT]  read address, unsigned.
REQ-014 modified  out  [LEFT:RIGHT]  read data after fault application.
REQ-015 do_write  in  1  write strobe.
REQ-016 write_address  in  [ADDR_LEFT:ADDR_RIGHT]  write address, unsigned.
REQ-017 fault_count  out  5  number of valid table entries.
REQ-018 overflow  out  1  sticky flag: an injection was dropped because the table was full.
REQ-019 injected  out  1  one-cycle pulse, one cycle after an injection is accepted.

Function
REQ-020 The block SHALL hold ENTRIES entries {valid, addr[AW], mask[W]} plus a prev_state register.
REQ-021 Trigger: state != prev_state, state != 32'hFFFFFFFF, state >= D_START, and off = state-D_START < (2^AW)*W; prev_state SHALL load state every cycle.
REQ-022 On trigger: bit = off[log2(W)-1:0], addr = off >> log2(W); the mask bit index SHALL be relative to RIGHT.
REQ-023 Trigger, valid entry with same addr: mask ^= onehot(bit); the entry SHALL be invalidated if mask becomes 0.
REQ-024 Trigger, no match, free entry: the lowest-index free entry SHALL be loaded with valid=1, addr, onehot(bit).
REQ-025 Trigger, no match, table full: the fault SHALL be dropped, overflow set to 1, and injected not pulsed.
REQ-026 injected SHALL pulse for cases REQ-023 and REQ-024 only.
REQ-027 modified SHALL equal unmodified ^ mask of the valid entry matching read_address when do_read=1 (combinational, zero latency), else unmodified.
REQ-028 Table updates SHALL become visible to reads one cycle after the triggering edge; a read in the trigger cycle SHALL see the old table.
REQ-029 STICKY=0: do_write SHALL invalidate a valid entry whose addr equals write_address at the next edge.
REQ-030 STICKY=1: writes SHALL not alter the table.
REQ-031 Write and trigger on the same addr in the same cycle: the write-clear SHALL apply first, then the trigger, so the entry SHALL hold only the new bit.
REQ-032 At most one entry SHALL match any address.
REQ-033 fault_count SHALL be the registered popcount of the valid bits.
REQ-034 overflow SHALL clear only on reset.

Reset
REQ-035 reset_n low SHALL immediately clear all valid bits and masks, set fault_count=0, overflow=0, injected=0 and prev_state=32'hFFFFFFFF.
REQ-036 During reset, modified SHALL equal unmodified; after deassertion, a held non-idle state SHALL trigger once.

Verification (W=8: LEFT=7, RIGHT=0; ADDR 3:0; D_START=100; ENTRIES=2; STICKY=0)
REQ-037 state=143 for 1 cycle -> injected pulse, fault_count=1; read addr 5 with unmodified=8'h00 -> modified=8'h08; holding state=143 -> no retrigger.
REQ-038 After REQ-037, write addr 5 -> fault_count=0 next cycle; read addr 5 with 8'hA5 -> 8'hA5.
REQ-039 Inject states 143, 108, 123 -> third injection dropped, overflow=1, fault_count=2; read addr 2 -> unmodified.
REQ-040 Inject 143, then FFFFFFFF, then 143 -> mask cancels, fault_count=0, injected pulsed twice.
REQ-041 state=99 or state=228 -> no table change, no injected pulse.
REQ-042 fault_count=1 with state held at 143, reset_n low mid-cycle -> outputs clear asynchronously; after release -> single retrigger, fault_count=1.
